// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Drains the UART RX FIFO one byte at a time and parses ASCII command
//   lines of the form <cmd><digits><term>:
//     cmd   'F'/'f' sets the frequency in Hz, 'D'/'d' sets the duty in percent
//     digits decimal, most significant first, at most MAX_DIGITS of them
//     term  CR (0x0D) or LF (0x0A)
//   A valid line updates freq_hz or duty_pct and pulses cfg_update. A bad line
//   pulses cmd_error once and leaves both registers unchanged.
//
// Ports
//   clk_50mhz   system clock
//   rst_n       asynchronous active-low reset
//   fifo_empty  RX FIFO empty flag
//   fifo_data   byte at the FIFO tail, valid while fifo_empty=0
//   fifo_read   one-cycle pop strobe to the RX FIFO
//   freq_hz     current PWM frequency, Hz
//   duty_pct    current duty cycle, 0..100
//   cfg_update  one-cycle pulse when freq_hz or duty_pct was just written
//   cmd_error   one-cycle pulse when a line is rejected
//   busy        high while a line is partially parsed
//
// FIFO handshake: fifo_empty is sampled only in S_WAIT. When it is low the
// FSM raises fifo_read for exactly one cycle (S_READ); fifo_data is captured
// at the edge that closes that cycle, which is also the edge on which the
// FIFO performs the pop. The byte is then decoded in S_DECODE, so a pop
// happens at most once every three cycles.
module uart_cmd_parser #(
  parameter int FREQ_WIDTH   = 24,
  parameter int FREQ_MAX     = 10_000_000,
  parameter int FREQ_DEFAULT = 1000,
  parameter int DUTY_DEFAULT = 50,
  parameter int MAX_DIGITS   = 8
) (
  input  logic                  clk_50mhz,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [7:0]            fifo_data,
  output logic                  fifo_read,
  output logic [FREQ_WIDTH-1:0] freq_hz,
  output logic [6:0]            duty_pct,
  output logic                  cfg_update,
  output logic                  cmd_error,
  output logic                  busy
);

  localparam int ACC_W = FREQ_WIDTH + 4;
  localparam int DIG_W = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_READ   = 2'd1,
    S_DECODE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PH_CMD  = 2'd0,
    PH_NUM  = 2'd1,
    PH_SKIP = 2'd2
  } phase_t;

  state_t           state;
  phase_t           phase;
  logic [7:0]       byte_reg;
  logic [ACC_W-1:0] acc;
  logic [DIG_W-1:0] ndig;
  logic             cmd_freq;

  // Byte classification and the next accumulator value.
  logic             is_digit;
  logic             is_term;
  logic             is_freq_cmd;
  logic             is_duty_cmd;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] acc_limit;
  logic             over_limit;
  logic             too_many;

  always_comb begin
    is_digit    = (byte_reg >= 8'h30) && (byte_reg <= 8'h39);
    is_term     = (byte_reg == 8'h0D) || (byte_reg == 8'h0A);
    is_freq_cmd = (byte_reg == 8'h46) || (byte_reg == 8'h66);
    is_duty_cmd = (byte_reg == 8'h44) || (byte_reg == 8'h64);
    // acc never exceeds FREQ_MAX, so acc*10+9 always fits in ACC_W bits.
    acc_next    = (acc * ACC_W'(10)) + {{(ACC_W-4){1'b0}}, byte_reg[3:0]};
    acc_limit   = cmd_freq ? ACC_W'(FREQ_MAX) : ACC_W'(100);
    over_limit  = acc_next > acc_limit;
    // Leading zeros count, so this rejects the digit that would be one too many.
    too_many    = ndig == DIG_W'(MAX_DIGITS);
  end

  assign busy = (phase != PH_CMD);

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_WAIT;
      phase      <= PH_CMD;
      byte_reg   <= 8'h00;
      acc        <= '0;
      ndig       <= '0;
      cmd_freq   <= 1'b0;
      fifo_read  <= 1'b0;
      freq_hz    <= FREQ_WIDTH'(FREQ_DEFAULT);
      duty_pct   <= 7'(DUTY_DEFAULT);
      cfg_update <= 1'b0;
      cmd_error  <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      cmd_error  <= 1'b0;
      case (state)
        S_WAIT: begin
          if (!fifo_empty) begin
            fifo_read <= 1'b1;
            state     <= S_READ;
          end
        end
        S_READ: begin
          byte_reg  <= fifo_data;
          fifo_read <= 1'b0;
          state     <= S_DECODE;
        end
        S_DECODE: begin
          state <= S_WAIT;
          case (phase)
            PH_CMD: begin
              if (is_freq_cmd || is_duty_cmd) begin
                cmd_freq <= is_freq_cmd;
                acc      <= '0;
                ndig     <= '0;
                phase    <= PH_NUM;
              end else if (!is_term) begin
                phase <= PH_SKIP;
              end
              // A terminator here is an empty line (e.g. LF after CR).
            end
            PH_NUM: begin
              if (is_digit) begin
                if (too_many || over_limit) begin
                  phase <= PH_SKIP;
                end else begin
                  acc  <= acc_next;
                  ndig <= ndig + DIG_W'(1);
                end
              end else if (is_term) begin
                phase <= PH_CMD;
                // Zero Hz would stall the PWM, so it is rejected; 0 % duty is legal.
                if ((ndig == '0) || (cmd_freq && (acc == '0))) begin
                  cmd_error <= 1'b1;
                end else begin
                  if (cmd_freq) freq_hz  <= acc[FREQ_WIDTH-1:0];
                  else          duty_pct <= acc[6:0];
                  cfg_update <= 1'b1;
                end
              end else begin
                phase <= PH_SKIP;
              end
            end
            PH_SKIP: begin
              if (is_term) begin
                cmd_error <= 1'b1;
                phase     <= PH_CMD;
              end
            end
            default: phase <= PH_CMD;
          endcase
        end
        default: begin
          state     <= S_WAIT;
          fifo_read <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: a queue-based RX FIFO model, a
// scoreboard of expected {freq_hz, duty_pct} per cfg_update, and pulse/pop
// timing checks.
module tb_uart_cmd_parser;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  // ---------------- clock / reset ----------------
  logic        clk_50mhz = 1'b0;
  logic        rst_n     = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data  = 8'h00;
  logic        fifo_read;
  logic [23:0] freq_hz;
  logic [6:0]  duty_pct;
  logic        cfg_update;
  logic        cmd_error;
  logic        busy;

  always #10 clk_50mhz = ~clk_50mhz;

  uart_cmd_parser dut (
    .clk_50mhz  (clk_50mhz),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_read  (fifo_read),
    .freq_hz    (freq_hz),
    .duty_pct   (duty_pct),
    .cfg_update (cfg_update),
    .cmd_error  (cmd_error),
    .busy       (busy)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_pop    = 0;
  int n_upd    = 0;
  int n_err    = 0;
  int exp_upd  = 0;
  int exp_err  = 0;
  int last_pop_cyc = -100;
  logic pend_pop = 1'b0;

  logic [7:0]  fifo_q[$];
  logic [30:0] exp_q[$];     // {freq_hz, duty_pct} expected at each cfg_update
  int          pop_cyc_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk_50mhz) cyc <= cyc + 1;

  // ---------------- FIFO model + monitor ----------------
  // The pop is applied one negedge after the strobe is seen, i.e. after the
  // DUT has captured fifo_data on the edge closing its read cycle.
  always @(negedge clk_50mhz) begin
    if (pend_pop) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pend_pop = 1'b0;
    end
    if (fifo_read) begin
      check("pop_nonempty", fifo_q.size() > 0, 1);
      check("pop_spacing", (cyc - last_pop_cyc) >= 3, 1);
      pend_pop = 1'b1;
      n_pop++;
      last_pop_cyc = cyc;
      pop_cyc_q.push_back(cyc);
    end
    if (cfg_update || cmd_error) begin
      check("pulse_excl", cfg_update && cmd_error, 0);
      check("pulse_latency", cyc - last_pop_cyc, 2);
    end
    if (cfg_update) begin
      n_upd++;
      check("exp_q_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        logic [30:0] e;
        e = exp_q.pop_front();
        check("upd_freq_hz", freq_hz, e[30:7]);
        check("upd_duty_pct", duty_pct, e[6:0]);
      end
    end
    if (cmd_error) n_err++;
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  // ---------------- driver tasks ----------------
  task automatic push_line(input string body, input logic [7:0] term);
    for (int i = 0; i < body.len(); i++) fifo_q.push_back(body[i]);
    fifo_q.push_back(term);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_50mhz);
      if (fifo_q.size() == 0 && !pend_pop) break;
    end
    check("drain_timeout", fifo_q.size(), 0);
    repeat (8) @(negedge clk_50mhz);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_n_upd"}, n_upd, exp_upd);
    check({tag, "_n_err"}, n_err, exp_err);
    check({tag, "_exp_q_empty"}, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk_50mhz);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_50mhz);

    // Reset, idle
    check("rst_freq_hz", freq_hz, 1000);
    check("rst_duty_pct", duty_pct, 50);
    check("rst_busy", busy, 0);
    check("rst_fifo_read", fifo_read, 0);
    check("rst_n_pop", n_pop, 0);
    check_counts("rst");

    // F2500 CR: six pops three cycles apart
    pop_cyc_q.delete();
    exp_q.push_back({24'd2500, 7'd50}); exp_upd++;
    push_line("F2500", CR);
    drain();
    check("f2500_pops", pop_cyc_q.size(), 6);
    for (int i = 1; i < 6 && i < pop_cyc_q.size(); i++)
      check("f2500_pop_gap", pop_cyc_q[i] - pop_cyc_q[i-1], 3);
    check("f2500_freq_hz", freq_hz, 2500);
    check("f2500_duty_pct", duty_pct, 50);
    check_counts("f2500");

    // d100 LF accepted, D101 CR rejected
    exp_q.push_back({24'd2500, 7'd100}); exp_upd++;
    push_line("d100", LF);
    push_line("D101", CR); exp_err++;
    drain();
    check("duty_edge_duty_pct", duty_pct, 100);
    check_counts("duty_edge");

    // Five malformed lines
    push_line("F10000001", CR);
    push_line("X5", CR);
    push_line("F", CR);
    push_line("F0", CR);
    push_line("F12a", CR);
    exp_err += 5;
    drain();
    check("bad_freq_hz", freq_hz, 2500);
    check("bad_duty_pct", duty_pct, 100);
    check_counts("bad");

    // FREQ_MAX boundary accepted
    exp_q.push_back({24'd10000000, 7'd100}); exp_upd++;
    push_line("f10000000", CR);
    drain();
    check("fmax_freq_hz", freq_hz, 10000000);
    check_counts("fmax");

    // Nine digits rejected; eight digits with leading zeros accepted; trailing LF empty
    push_line("F000000001", CR); exp_err++;
    exp_q.push_back({24'd7, 7'd100}); exp_upd++;
    push_line("F00000007", CR);
    fifo_q.push_back(LF);
    drain();
    check("digits_freq_hz", freq_hz, 7);
    check("digits_busy", busy, 0);
    check_counts("digits");

    // Reset mid-line
    push_line("F1", 8'h32);   // "F12" with no terminator
    drain();
    check("midline_busy", busy, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk_50mhz);
    check("inrst_freq_hz", freq_hz, 1000);
    check("inrst_duty_pct", duty_pct, 50);
    check("inrst_busy", busy, 0);
    check("inrst_fifo_read", fifo_read, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_50mhz);
    exp_q.push_back({24'd1000, 7'd25}); exp_upd++;
    push_line("D25", CR);
    drain();
    check("post_rst_duty_pct", duty_pct, 25);
    check("post_rst_freq_hz", freq_hz, 1000);
    check_counts("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
